shift_seq: RTL and testbench

Multi-cycle, register-specified shift unit for the multicycle datapath: it executes LSL/LSR/ASR/ROR/RRX by an 8-bit amount one bit per clock. It also produces the shifter carry-out that the single-cycle immediate-amount shifter does not produce. It sits beside the ALU and is launched by the control FSM with a start/done handshake whenever Operand2 uses a register-held shift amount (Rs[7:0]). The shift-type encoding matches the existing shifter exactly.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_count_calc.sv | 39 +++
 rtl/shift_seq.sv | 116 +++++++++++
 tb/tb_shift_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared shifter definitions: shift-type encoding, sequencer states and count width.
package shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Step count holds up to WIDTH+1 (LSL/LSR by 33 at WIDTH=32).
  localparam int unsigned K_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_count_calc.sv
// Converts a register shift amount and type into the number of 1-bit steps to run.
module shift_count_calc
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       shtype,
  input  logic             rrx,
  output logic [K_W-1:0]   k
);

  localparam int unsigned LOG_W = $clog2(WIDTH);

  logic [LOG_W-1:0] amt_lo;

  assign amt_lo = amt[LOG_W-1:0];

  // Clamp so that over-range shifts leave exactly the architectural result.
  always_comb begin
    k = '0;
    case (shtype)
      SH_LSL, SH_LSR: k = (amt > AMT_W'(WIDTH + 1)) ? K_W'(WIDTH + 1) : K_W'(amt);
      SH_ASR:         k = (amt > AMT_W'(WIDTH)) ? K_W'(WIDTH) : K_W'(amt);
      default: begin
        if (rrx)
          k = K_W'(1);
        else if (amt_lo != '0)
          k = K_W'(amt_lo);
        else if (amt != '0)
          k = K_W'(WIDTH);
        else
          k = '0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle register-amount shifter: one bit per clock, start/done handshake, carry-out.
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       shtype,
  input  logic             rrx,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  state_t           state;
  logic [K_W-1:0]   k_q;
  logic [K_W-1:0]   k_c;
  logic [1:0]       type_q;
  logic             rrx_q;
  logic [WIDTH-1:0] y_step;
  logic             c_step;

  shift_count_calc #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_count (
    .amt    (amt),
    .shtype (shtype),
    .rrx    (rrx),
    .k      (k_c)
  );

  // One 1-bit step of the latched operation; cout doubles as the carry register.
  always_comb begin
    y_step = y;
    c_step = cout;
    case (type_q)
      SH_LSL: begin
        c_step = y[WIDTH-1];
        y_step = {y[WIDTH-2:0], 1'b0};
      end
      SH_LSR: begin
        c_step = y[0];
        y_step = {1'b0, y[WIDTH-1:1]};
      end
      SH_ASR: begin
        c_step = y[0];
        y_step = {y[WIDTH-1], y[WIDTH-1:1]};
      end
      default: begin
        c_step = y[0];
        y_step = {(rrx_q ? cout : y[0]), y[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      k_q    <= '0;
      type_q <= SH_LSL;
      rrx_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            y      <= a;
            cout   <= cin;
            type_q <= shtype;
            rrx_q  <= rrx;
            k_q    <= k_c;
            busy   <= 1'b1;
            if (k_c != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          y    <= y_step;
          cout <= c_step;
          k_q  <= k_q - K_W'(1);
          if (k_q == K_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: arithmetic reference model plus directed literal cases.
module tb_shift_seq;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [7:0]  amt = '0;
  logic [1:0]  shtype = '0;
  logic        rrx = 1'b0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [31:0] y;

  int errors = 0;
  int checks = 0;

  // Model state: m_rem < 0 idle, otherwise cycles left until the done cycle.
  int          m_rem = -1;
  logic [31:0] m_y = '0;
  logic        m_c = 1'b0;

  shift_seq #(.WIDTH(32), .AMT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .amt    (amt),
    .shtype (shtype),
    .rrx    (rrx),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Architectural result computed directly from the shift rules.
  function automatic void model_op(input logic [31:0] va, input logic [7:0] vamt,
                                   input logic [1:0] vt, input logic vrrx, input logic vcin,
                                   output logic [31:0] ey, output logic ec, output int k);
    int n, r;
    n = int'(vamt);
    ey = va;
    ec = vcin;
    k = 0;
    case (vt)
      T_LSL: begin
        k = (n > 33) ? 33 : n;
        if (n == 0) begin ey = va; ec = vcin; end
        else if (n < 32) begin ey = va << n; ec = va[32-n]; end
        else if (n == 32) begin ey = '0; ec = va[0]; end
        else begin ey = '0; ec = 1'b0; end
      end
      T_LSR: begin
        k = (n > 33) ? 33 : n;
        if (n == 0) begin ey = va; ec = vcin; end
        else if (n < 32) begin ey = va >> n; ec = va[n-1]; end
        else if (n == 32) begin ey = '0; ec = va[31]; end
        else begin ey = '0; ec = 1'b0; end
      end
      T_ASR: begin
        k = (n > 32) ? 32 : n;
        if (n == 0) begin ey = va; ec = vcin; end
        else if (n < 32) begin ey = 32'($signed(va) >>> n); ec = va[n-1]; end
        else begin ey = {32{va[31]}}; ec = va[31]; end
      end
      default: begin
        r = n % 32;
        if (vrrx) begin k = 1; ey = {vcin, va[31:1]}; ec = va[0]; end
        else if (n == 0) begin k = 0; ey = va; ec = vcin; end
        else if (r == 0) begin k = 32; ey = va; ec = va[31]; end
        else begin k = r; ey = (va >> r) | (va << (32 - r)); ec = va[r-1]; end
      end
    endcase
  endfunction

  // Handshake model: accept only when idle, one done cycle, then one idle cycle.
  always @(posedge clk or posedge reset) begin
    logic [31:0] ey;
    logic        ec;
    int          k;
    if (reset) begin
      m_rem = -1;
      m_y   = '0;
      m_c   = 1'b0;
    end else if (m_rem < 0) begin
      if (start) begin
        model_op(a, amt, shtype, rrx, cin, ey, ec, k);
        m_y   = ey;
        m_c   = ec;
        m_rem = k;
      end
    end else if (m_rem == 0) begin
      m_rem = -1;
    end else begin
      m_rem = m_rem - 1;
    end
  end

  // Per-cycle comparison against the model; results only checked once they are valid.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_rem >= 0));
    chk("done", 32'(done), 32'(m_rem == 0));
    if (m_rem <= 0) begin
      chk("y", y, m_y);
      chk("cout", 32'(cout), 32'(m_c));
    end
  end

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [7:0] tamt,
                        input logic [1:0] tt, input logic trrx, input logic tcin,
                        input logic [31:0] ey, input logic ec, input int elat, input bit pulse);
    int lat;
    bit seen;
    @(negedge clk);
    #1;
    a = ta; amt = tamt; shtype = tt; rrx = trrx; cin = tcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; amt = tamt + 8'd7; shtype = ~tt; rrx = ~trrx; cin = ~tcin;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (pulse && lat == 2) start = 1'b1;
      else if (pulse && lat == 3) start = 1'b0;
    end
    start = 1'b0;
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " y"}, y, ey);
    chk({nm, " cout"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int pulses;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset y", y, 32'd0);
    #1 reset = 1'b0;

    run_op("lsl1",   32'h8000_0001, 8'd1,   T_LSL, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 2,  1'b0);
    run_op("asr40",  32'h8000_0000, 8'd40,  T_ASR, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 33, 1'b0);
    run_op("lsr32",  32'h8000_0000, 8'd32,  T_LSR, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 33, 1'b0);
    run_op("lsr33",  32'h8000_0000, 8'd33,  T_LSR, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 34, 1'b0);
    run_op("ror8",   32'h1234_5678, 8'd8,   T_ROR, 1'b0, 1'b1, 32'h7812_3456, 1'b0, 9,  1'b0);
    run_op("ror64",  32'h1234_5678, 8'd64,  T_ROR, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 33, 1'b0);
    run_op("ror0",   32'h1234_5678, 8'd0,   T_ROR, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1,  1'b0);
    run_op("rrx",    32'h0000_0003, 8'd200, T_ROR, 1'b1, 1'b1, 32'h8000_0001, 1'b1, 2,  1'b0);
    run_op("lsl32",  32'h0000_0001, 8'd32,  T_LSL, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 33, 1'b0);
    run_op("lsl40",  32'hFFFF_FFFF, 8'd40,  T_LSL, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 34, 1'b0);
    run_op("asr4",   32'h8000_0010, 8'd4,   T_ASR, 1'b0, 1'b1, 32'hF800_0001, 1'b0, 5,  1'b0);
    run_op("lsl0",   32'h0000_0055, 8'd0,   T_LSL, 1'b0, 1'b0, 32'h0000_0055, 1'b0, 1,  1'b0);
    run_op("pulse",  32'h0000_0001, 8'd5,   T_LSL, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 6,  1'b1);

    // Held start: accepted, ignored in the done cycle, accepted again after idle.
    @(negedge clk);
    #1;
    a = 32'hCAFE_0001; amt = 8'd0; shtype = T_ROR; rrx = 1'b0; cin = 1'b1; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    #1 start = 1'b0;
    chk("held_start pulses", 32'(pulses), 32'd3);

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    #1;
    a = 32'hFFFF_FFFF; amt = 8'd20; shtype = T_LSL; rrx = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort y", y, 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no_done", 32'(pulses), 32'd0);

    run_op("post_reset", 32'h0000_00F8, 8'd4, T_LSR, 1'b0, 1'b0, 32'h0000_000F, 1'b1, 5, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
